cache_writeback: RTL

CACHE_WRITEBACK -- requirements
Module: cache_writeback

---
 rtl/cache_writeback_pkg.sv | 19 +
 rtl/cache_writeback.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cache_writeback_pkg.sv
// Shared definitions for the cache line write-back engine: FSM states,
// bus data width and the OKAY write-response code.
package cache_writeback_pkg;

  localparam int unsigned DATA_BUS = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_CLEAN,
    ST_DONE
  } wb_state_e;

endpackage

// File: rtl/cache_writeback.sv
// Evicts one cache line as a single write burst, then marks the line clean.
// Optional feature: define CACHE_WB_RETRY_EN to resend the burst on an error response.
module cache_writeback
  import cache_writeback_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_start,
  input  logic [INDEX_WIDTH-1:0]  wb_index,
  output logic                    wb_busy,
  output logic                    wb_done,
  input  logic                    line_valid,
  input  logic                    line_dirty,
  input  logic [TAG_WIDTH-1:0]    line_tag,
  input  logic [DATA_BUS-1:0]     line_data,
  output logic [OFFSET_WIDTH-1:0] line_offset,
  output logic                    line_write_en,
  output logic                    line_valid_in,
  output logic                    line_dirty_in,
  output logic [TAG_WIDTH-1:0]    line_tag_in,
  output logic [3:0]              line_byte_en,
  output logic                    mem_awvalid,
  input  logic                    mem_awready,
  output logic [31:0]             mem_addr,
  output logic [7:0]              mem_len,
  output logic                    mem_wvalid,
  input  logic                    mem_wready,
  output logic [DATA_BUS-1:0]     mem_wdata,
  output logic                    mem_wlast,
  input  logic                    mem_bvalid,
  output logic                    mem_bready,
  input  logic [1:0]              mem_bresp
);

  localparam int unsigned ADDR_FULL_W = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + 2;
  localparam logic [7:0]  BURST_LEN   = 8'((2 ** OFFSET_WIDTH) - 1);

  wb_state_e               state, state_nxt;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [INDEX_WIDTH-1:0]  idx_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [ADDR_FULL_W-1:0]  addr_full;
  logic                    last_beat;

`ifdef CACHE_WB_RETRY_EN
  logic resp_err;
  assign resp_err = (mem_bresp != RESP_OKAY);
`else
  logic unused_bresp;
  assign unused_bresp = ^mem_bresp;
`endif

  assign addr_full = {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}, 2'b00};
  assign last_beat = (cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx_q <= '0;
      tag_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && wb_start)
        idx_q <= wb_index;
      if (state == ST_CHECK && line_valid && line_dirty)
        tag_q <= line_tag;
      // Counter wraps to zero on the last beat, so a resent burst starts at beat 0.
      if (state == ST_ADDR)
        cnt <= '0;
      else if (state == ST_DATA && mem_wready)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (wb_start) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (line_valid && line_dirty) ? ST_ADDR : ST_DONE;
      ST_ADDR:  if (mem_awready) state_nxt = ST_DATA;
      ST_DATA:  if (mem_wready && last_beat) state_nxt = ST_RESP;
      ST_RESP: begin
        if (mem_bvalid) begin
`ifdef CACHE_WB_RETRY_EN
          state_nxt = resp_err ? ST_ADDR : ST_CLEAN;
`else
          state_nxt = ST_CLEAN;
`endif
        end
      end
      ST_CLEAN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_busy       = (state != ST_IDLE);
    wb_done       = (state == ST_DONE);
    line_offset   = cnt;
    line_write_en = (state == ST_CLEAN);
    line_valid_in = (state == ST_CLEAN);
    line_dirty_in = 1'b0;
    line_tag_in   = tag_q;
    line_byte_en  = '0;
    mem_awvalid   = (state == ST_ADDR);
    mem_addr      = 32'(addr_full);
    mem_len       = BURST_LEN;
    mem_wvalid    = (state == ST_DATA);
    mem_wdata     = (state == ST_DATA) ? line_data : '0;
    mem_wlast     = (state == ST_DATA) && last_beat;
    mem_bready    = (state == ST_RESP);
  end

endmodule
